// File: rtl/mem_access_unit_pkg.sv
// Shared data-type codes, exception codes and lane helpers for the MEM-stage access unit.
// The optional bus timeout lives in the top and is enabled by defining MEM_TIMEOUT_EN.
package mem_access_unit_pkg;

    localparam logic [3:0] DT_W  = 4'd0;
    localparam logic [3:0] DT_HU = 4'd1;
    localparam logic [3:0] DT_H  = 4'd2;
    localparam logic [3:0] DT_BU = 4'd3;
    localparam logic [3:0] DT_B  = 4'd4;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    typedef enum logic [1:0] {
        SZ_WORD,
        SZ_HALF,
        SZ_BYTE
    } accSize_e;

    // Unknown type codes fall back to a full word access.
    function automatic accSize_e sizeOf(input logic [3:0] dt);
        case (dt)
            DT_HU, DT_H: sizeOf = SZ_HALF;
            DT_BU, DT_B: sizeOf = SZ_BYTE;
            default:     sizeOf = SZ_WORD;
        endcase
    endfunction

    function automatic logic isMisaligned(input accSize_e sz, input logic [1:0] off);
        case (sz)
            SZ_WORD: isMisaligned = (off != 2'b00);
            SZ_HALF: isMisaligned = off[0];
            default: isMisaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byteEnable(input accSize_e sz, input logic [1:0] off);
        case (sz)
            SZ_HALF: byteEnable = off[1] ? 4'b1100 : 4'b0011;
            SZ_BYTE: byteEnable = 4'b0001 << off;
            default: byteEnable = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] laneData(input accSize_e sz, input logic [31:0] wdata);
        case (sz)
            SZ_HALF: laneData = {2{wdata[15:0]}};
            SZ_BYTE: laneData = {4{wdata[7:0]}};
            default: laneData = wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data bus between the MEM-stage access unit (master) and a memory slave.
// bus_rdata is only meaningful in a cycle where bus_ack is high.
interface mem_access_unit_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );

endinterface

// File: rtl/mem_access_unit_load_ext.sv
// Load lane select and extension: picks the addressed byte/half of a bus word
// and zero- or sign-extends it according to the data type code.
module load_ext
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [3:0]  i_type,
    output logic [31:0] o_result
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
        case (i_off)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
    end

    always_comb begin
        case (i_type)
            DT_HU:   o_result = {16'h0000, w_half};
            DT_H:    o_result = {{16{w_half[15]}}, w_half};
            DT_BU:   o_result = {24'h000000, w_byte};
            DT_B:    o_result = {{24{w_byte[7]}}, w_byte};
            default: o_result = i_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: req/ack bus master with alignment checks.
// Define MEM_TIMEOUT_EN to add a bus-wait watchdog that ends the access with a DBE exception.
module mem_access_unit
   import mem_access_unit_pkg::*;
   #(parameter logic [7:0] TIMEOUT = 8'd255)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              MemtoRegM,
   input  logic              MemWriteM,
   input  logic [3:0]        DataTypeM,
   input  logic [31:0]       ALUResM,
   input  logic [31:0]       WriteDataM,
   input  logic              ExcOccurM,
   input  logic              flushM,
   mem_access_unit_if.master bus,
   output logic              StallM,
   output logic [31:0]       ReadDataM,
   output logic              MemExcM,
   output logic [4:0]        MemExcCodeM
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_DONE
   } state_e;

   state_e      r_state;
   state_e      w_nextState;

   accSize_e    w_size;
   logic        w_access;
   logic        w_misalign;
   logic        w_start;
   logic        w_timeout;
   logic        w_timedOut;
   logic [31:0] w_loadResult;

   logic        r_req;
   logic        r_we;
   logic        r_isLoad;
   logic        r_flushed;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic [3:0]  r_be;
   logic [3:0]  r_type;
   logic [1:0]  r_off;

   assign w_size     = sizeOf(DataTypeM);
   assign w_access   = (MemtoRegM | MemWriteM) & ~ExcOccurM & ~flushM;
   assign w_misalign = isMisaligned(w_size, ALUResM[1:0]);
   assign w_start    = (r_state == ST_IDLE) && w_access && !w_misalign;

`ifdef MEM_TIMEOUT_EN
   logic [7:0] r_cnt;
   logic       r_timedOut;

   // Fires on the REQ cycle whose missing ack would bring the wait count to TIMEOUT.
   assign w_timeout  = (r_state == ST_REQ) && !bus.bus_ack && ((r_cnt + 8'd1) == TIMEOUT);
   assign w_timedOut = r_timedOut;

   // Wait counter: cleared when an access starts, counts REQ cycles without ack.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt      <= 8'd0;
         r_timedOut <= 1'b0;
      end else if (w_start) begin
         r_cnt      <= 8'd0;
         r_timedOut <= 1'b0;
      end else if ((r_state == ST_REQ) && !bus.bus_ack) begin
         if (w_timeout) begin
            r_cnt      <= 8'd0;
            r_timedOut <= 1'b1;
         end else begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end
`else
   assign w_timeout  = 1'b0;
   assign w_timedOut = 1'b0;
`endif

   load_ext u_loadExt (
      .i_word   (r_rdata),
      .i_off    (r_off),
      .i_type   (r_type),
      .o_result (w_loadResult)
   );

   // State register for the access FSM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and combinational outputs: stall, exceptions and load result.
   always_comb begin
      w_nextState = r_state;
      StallM      = 1'b0;
      MemExcM     = 1'b0;
      MemExcCodeM = 5'd0;
      ReadDataM   = 32'd0;
      case (r_state)
         ST_IDLE: begin
            if (w_access && w_misalign) begin
               MemExcM     = 1'b1;
               MemExcCodeM = MemWriteM ? EXC_ADES : EXC_ADEL;
            end else if (w_start) begin
               StallM      = 1'b1;
               w_nextState = ST_REQ;
            end
         end
         ST_REQ: begin
            StallM = 1'b1;
            if (bus.bus_ack || w_timeout) begin
               w_nextState = ST_DONE;
            end
         end
         ST_DONE: begin
            w_nextState = ST_IDLE;
            if (w_timedOut) begin
               MemExcM     = 1'b1;
               MemExcCodeM = EXC_DBE;
            end else if (r_isLoad && !r_flushed) begin
               ReadDataM = w_loadResult;
            end
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   // Bus outputs are latched at the start of an access and held steady for the whole of REQ;
   // a flush seen in REQ only poisons the result, the transfer itself always completes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_req     <= 1'b0;
         r_we      <= 1'b0;
         r_isLoad  <= 1'b0;
         r_flushed <= 1'b0;
         r_addr    <= 32'd0;
         r_wdata   <= 32'd0;
         r_rdata   <= 32'd0;
         r_be      <= 4'd0;
         r_type    <= 4'd0;
         r_off     <= 2'd0;
      end else if (w_start) begin
         r_req     <= 1'b1;
         r_we      <= MemWriteM;
         r_isLoad  <= ~MemWriteM;
         r_flushed <= 1'b0;
         r_addr    <= {ALUResM[31:2], 2'b00};
         r_be      <= byteEnable(w_size, ALUResM[1:0]);
         r_wdata   <= MemWriteM ? laneData(w_size, WriteDataM) : 32'd0;
         r_type    <= DataTypeM;
         r_off     <= ALUResM[1:0];
      end else if (r_state == ST_REQ) begin
         if (flushM) begin
            r_flushed <= 1'b1;
         end
         if (bus.bus_ack) begin
            r_req   <= 1'b0;
            r_rdata <= bus.bus_rdata;
         end else if (w_timeout) begin
            r_req <= 1'b0;
         end
      end
   end

   assign bus.bus_req   = r_req;
   assign bus.bus_we    = r_we;
   assign bus.bus_addr  = r_addr;
   assign bus.bus_be    = r_be;
   assign bus.bus_wdata = r_wdata;

endmodule
